mux_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 2:1 multiplexer datapath. Two requesters compete for one output channel. The block drives the mux select, issues registered grants, and produces a registered output beat stream. It holds a grant for a whole burst, delimited by last0/last1, and then hands ownership over fairly. It sits between the requester logic and the downstream consumer of the muxed output.

---
 rtl/mux_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 2:1 mux with burst-held grants.
// Optional macro GRANT_TIMEOUT_EN adds a per-grant beat limit (MAX_GRANT) forcing handover when contended.
module mux_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_GRANT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic              last0,
    input  logic              last1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   ptr, ptr_nxt;
    logic   sel_nxt;
    logic   acc0, acc1;
    logic   rel0, rel1;
    logic   to0, to1;

    if (MAX_GRANT < 2 || MAX_GRANT > 255) begin : g_max_grant_range
        $error("MAX_GRANT must lie in 2..255");
    end

    assign acc0 = (state == GNT0) && req0;
    assign acc1 = (state == GNT1) && req1;

`ifdef GRANT_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(MAX_GRANT - 1);
    logic [7:0] cnt;

    // Forced handover only on the beat that reaches the limit, and only if the peer is waiting.
    assign to0 = acc0 && (cnt == CNT_LAST) && req1;
    assign to1 = acc1 && (cnt == CNT_LAST) && req0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (state_nxt != state) begin
            cnt <= 8'd0;
        end else if ((acc0 || acc1) && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end
`else
    assign to0 = 1'b0;
    assign to1 = 1'b0;
`endif

    // A withdrawn request releases regardless of last; last is only meaningful with req.
    assign rel0 = (state == GNT0) && (!req0 || last0 || to0);
    assign rel1 = (state == GNT1) && (!req1 || last1 || to1);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = ptr ? GNT1 : GNT0;
                end else if (req0) begin
                    state_nxt = GNT0;
                end else if (req1) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (rel0) begin
                    ptr_nxt   = 1'b1;
                    state_nxt = req1 ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (rel1) begin
                    ptr_nxt   = 1'b0;
                    state_nxt = req0 ? GNT0 : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (state_nxt == GNT0) begin
            sel_nxt = 1'b0;
        end else if (state_nxt == GNT1) begin
            sel_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            sel       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            sel       <= sel_nxt;
            out_valid <= acc0 || acc1;
            if (acc1) begin
                out_data <= data1;
            end else if (acc0) begin
                out_data <= data0;
            end
        end
    end

    assign gnt0 = (state == GNT0);
    assign gnt1 = (state == GNT1);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus randomized traffic
// compared against an ownership-level reference model.
module tb_mux_rr_arbiter;

    localparam int DATA_W = 8;
    localparam int MG     = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              req0  = 1'b0;
    logic              req1  = 1'b0;
    logic              last0 = 1'b0;
    logic              last1 = 1'b0;
    logic [DATA_W-1:0] data0 = '0;
    logic [DATA_W-1:0] data1 = '0;
    logic              gnt0, gnt1, sel, out_valid, busy;
    logic [DATA_W-1:0] out_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.DATA_W(DATA_W), .MAX_GRANT(MG)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .data0    (data0),
        .data1    (data1),
        .last0    (last0),
        .last1    (last1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .sel      (sel),
        .out_valid(out_valid),
        .out_data (out_data),
        .busy     (busy)
    );

    // Reference model: owner is -1 when nobody holds the mux.
    int              m_owner = -1;
    int              m_ptr   = 0;
    int              m_cnt   = 0;
    logic            m_sel   = 1'b0;
    logic            m_ov    = 1'b0;
    logic [DATA_W-1:0] m_od  = '0;

    always @(posedge clk) begin : ref_model
        int nown, nptr, ncnt, oth;
        logic acc, rel;
        logic [1:0] rq, ls;
        rq   = {req1, req0};
        ls   = {last1, last0};
        nown = m_owner;
        nptr = m_ptr;
        oth  = 0;
        acc  = 1'b0;
        rel  = 1'b0;
        if (!rst_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_cnt   <= 0;
            m_sel   <= 1'b0;
            m_ov    <= 1'b0;
            m_od    <= '0;
        end else begin
            if (m_owner < 0) begin
                if (rq[0] && rq[1]) nown = m_ptr;
                else if (rq[0])     nown = 0;
                else if (rq[1])     nown = 1;
            end else begin
                oth = 1 - m_owner;
                acc = rq[m_owner];
                rel = !rq[m_owner] || ls[m_owner];
`ifdef GRANT_TIMEOUT_EN
                if (acc && (m_cnt + 1 == MG) && rq[oth]) rel = 1'b1;
`endif
                if (rel) begin
                    nptr = oth;
                    nown = rq[oth] ? oth : -1;
                end
            end
            if (nown != m_owner)          ncnt = 0;
            else if (acc && m_cnt < 255)  ncnt = m_cnt + 1;
            else                          ncnt = m_cnt;
            m_owner <= nown;
            m_ptr   <= nptr;
            m_cnt   <= ncnt;
            m_ov    <= acc;
            if (acc) m_od <= (m_owner == 1) ? data1 : data0;
            if (nown >= 0) m_sel <= (nown == 1);
        end
    end

    function automatic logic [12:0] exp_vec();
        return {m_owner == 0, m_owner == 1, m_sel, m_ov, m_od, m_owner >= 0};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {gnt0, gnt1, sel, out_valid, out_data, busy};
    endfunction

    // Drives one cycle of inputs at the falling edge and returns at the next falling edge.
    task automatic run_cycle(input logic r0, input logic r1, input logic l0, input logic l1,
                             input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        req0  = r0;
        req1  = r1;
        last0 = l0;
        last1 = l1;
        data0 = d0;
        data1 = d1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run_cycle(0, 0, 0, 0, 8'h00, 8'h00);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] o;
        rst_n = 1'b0;
        run_cycle(0, 0, 0, 0, 8'h00, 8'h00);
        run_cycle(0, 0, 0, 0, 8'h00, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_cycle(0, 0, 0, 0, 8'h00, 8'h00);
            o = obs_vec();
            n_cmp++;
            if (o !== 13'h0000) begin
                n_bad++;
                $display("FAIL reset_idle[%0d]: got %h want %h", i, o, 13'h0000);
            end
        end
    endtask

    task automatic test_single_burst();
        logic [7:0] d[4];
        logic       l[4];
        logic [12:0] o, e;
        d = '{8'h11, 8'h11, 8'h22, 8'h33};
        l = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_cycle(1, 0, l[i], 0, d[i], 8'h00);
            o = obs_vec();
            e = exp_vec();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL single_model[%0d]: got %h want %h", i, o, e);
            end
            n_cmp++;
            if (i == 0 && !(gnt0 === 1'b1 && out_valid === 1'b0)) begin
                n_bad++;
                $display("FAIL single_gnt: got gnt0=%b ov=%b want gnt0=1 ov=0", gnt0, out_valid);
            end else if (i > 0 && !(out_valid === 1'b1 && out_data === d[i])) begin
                n_bad++;
                $display("FAIL single_beat[%0d]: got ov=%b data=%h want ov=1 data=%h",
                         i, out_valid, out_data, d[i]);
            end
        end
        run_cycle(0, 0, 0, 0, 8'h00, 8'h00);
        n_cmp++;
        if (!(out_valid === 1'b0 && busy === 1'b0 && gnt0 === 1'b0 && out_data === 8'h33)) begin
            n_bad++;
            $display("FAIL single_end: got ov=%b busy=%b gnt0=%b data=%h want 0 0 0 33",
                     out_valid, busy, gnt0, out_data);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] want[4];
        int         nv;
        logic [12:0] o, e;
        want = '{8'hA1, 8'hA2, 8'hB1, 8'hB2};
        nv   = 0;
        do_reset();
        run_cycle(1, 1, 0, 0, 8'hA1, 8'hB1);
        n_cmp++;
        if (!(gnt0 === 1'b1 && gnt1 === 1'b0 && sel === 1'b0)) begin
            n_bad++;
            $display("FAIL simul_first: got gnt0=%b gnt1=%b sel=%b want 1 0 0", gnt0, gnt1, sel);
        end
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: run_cycle(1, 1, 0, 0, 8'hA1, 8'hB1);
                1: run_cycle(1, 1, 1, 0, 8'hA2, 8'hB1);
                2: run_cycle(0, 1, 0, 0, 8'h00, 8'hB1);
                default: run_cycle(0, 1, 0, 1, 8'h00, 8'hB2);
            endcase
            o = obs_vec();
            e = exp_vec();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL simul_model[%0d]: got %h want %h", i, o, e);
            end
            if (out_valid === 1'b1) nv++;
            n_cmp++;
            if (!(out_valid === 1'b1 && out_data === want[i])) begin
                n_bad++;
                $display("FAIL simul_beat[%0d]: got ov=%b data=%h want ov=1 data=%h",
                         i, out_valid, out_data, want[i]);
            end
            if (i == 1) begin
                n_cmp++;
                if (!(gnt1 === 1'b1 && sel === 1'b1 && gnt0 === 1'b0)) begin
                    n_bad++;
                    $display("FAIL simul_handover: got gnt1=%b sel=%b want 1 1", gnt1, sel);
                end
            end
        end
        n_cmp++;
        if (nv != 4) begin
            n_bad++;
            $display("FAIL simul_count: got %0d want 4", nv);
        end
        run_cycle(0, 0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_fairness();
        logic [12:0] o, e;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_cycle(1, 1, 1, 1, 8'($urandom), 8'($urandom));
            o = obs_vec();
            e = exp_vec();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL fair_model[%0d]: got %h want %h", i, o, e);
            end
            n_cmp++;
            if (gnt0 !== ((i % 2) == 0) || sel !== ((i % 2) == 1)) begin
                n_bad++;
                $display("FAIL fair_alt[%0d]: got gnt0=%b sel=%b want gnt0=%b sel=%b",
                         i, gnt0, sel, (i % 2) == 0, (i % 2) == 1);
            end
        end
        run_cycle(0, 0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_withdraw_and_reset();
        logic [12:0] o;
        do_reset();
        run_cycle(1, 0, 1, 0, 8'h01, 8'h00);  // grant 0
        run_cycle(1, 0, 1, 0, 8'h01, 8'h00);  // single beat, pointer moves to 1
        run_cycle(0, 1, 0, 0, 8'h00, 8'h20);  // grant 1
        run_cycle(0, 1, 0, 0, 8'h00, 8'h21);
        run_cycle(0, 1, 0, 0, 8'h00, 8'h22);
        run_cycle(0, 0, 0, 0, 8'h00, 8'h00);  // withdrawal without last1
        n_cmp++;
        if (!(busy === 1'b0 && gnt1 === 1'b0 && out_valid === 1'b0)) begin
            n_bad++;
            $display("FAIL withdraw_release: got busy=%b gnt1=%b ov=%b want 0 0 0", busy, gnt1, out_valid);
        end
        run_cycle(1, 1, 0, 0, 8'h30, 8'h40);
        n_cmp++;
        if (!(gnt0 === 1'b1 && gnt1 === 1'b0)) begin
            n_bad++;
            $display("FAIL withdraw_ptr: got gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
        end
        run_cycle(1, 0, 0, 0, 8'h31, 8'h00);
        run_cycle(1, 0, 0, 0, 8'h32, 8'h00);
        rst_n = 1'b0;
        run_cycle(1, 0, 0, 0, 8'h33, 8'h00);
        rst_n = 1'b1;
        o = obs_vec();
        n_cmp++;
        if (o !== 13'h0000) begin
            n_bad++;
            $display("FAIL midburst_reset: got %h want %h", o, 13'h0000);
        end
        run_cycle(0, 0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_random();
        logic [12:0] o, e;
        logic r0, r1;
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            run_cycle(r0, r1, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                      8'($urandom), 8'($urandom));
            o = obs_vec();
            e = exp_vec();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL random[%0d]: got %h want %h", i, o, e);
            end
        end
        rst_n = 1'b1;
        run_cycle(0, 0, 0, 0, 8'h00, 8'h00);
    endtask

`ifdef GRANT_TIMEOUT_EN
    task automatic test_timeout();
        int ng;
        logic [12:0] o, e;
        do_reset();
        ng = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle(1, 1, 0, 0, 8'(8'h50 + i), 8'h60);
            o = obs_vec();
            e = exp_vec();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL timeout_model[%0d]: got %h want %h", i, o, e);
            end
            if (gnt0 === 1'b1) ng++;
        end
        n_cmp++;
        if (!(ng == MG && gnt1 === 1'b1)) begin
            n_bad++;
            $display("FAIL timeout_handover: got gnt0 cycles=%0d gnt1=%b want %0d 1", ng, gnt1, MG);
        end
        do_reset();
        ng = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle(1, 0, 0, 0, 8'(8'h70 + i), 8'h00);
            if (gnt0 === 1'b1) ng++;
        end
        n_cmp++;
        if (ng != 10) begin
            n_bad++;
            $display("FAIL timeout_hold: got gnt0 cycles=%0d want 10", ng);
        end
        run_cycle(0, 0, 0, 0, 8'h00, 8'h00);
    endtask
`endif

    initial begin
        test_reset();
        test_single_burst();
        test_simultaneous();
        test_fairness();
        test_withdraw_and_reset();
        test_random();
`ifdef GRANT_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
